// File: rtl/fifo_pkg.sv
// ----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the asynchronous FIFO pointer logic.
//   FIFO_ADDR_SIZE  : default RAM address width (depth = 2**FIFO_ADDR_SIZE)
//   FIFO_DATA_WIDTH : default RAM word width
//   bin2gray()      : binary -> reflected Gray code
//   gray2bin()      : reflected Gray code -> binary (XOR prefix from the MSB)
// The conversion functions work on a fixed GRAY_MAX_W-bit container. Callers
// zero-extend narrower pointers into it and truncate the result back. Both
// conversions are unaffected by leading zeros, so this gives a width-generic
// conversion for any pointer up to GRAY_MAX_W bits.
// ----------------------------------------------------------------------------
package fifo_pkg;

    localparam int FIFO_ADDR_SIZE  = 9;
    localparam int FIFO_DATA_WIDTH = 32;
    localparam int GRAY_MAX_W      = 32;

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return (b >> 1) ^ b;
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fwft_skid2.sv
// ----------------------------------------------------------------------------
// fwft_skid2
// Two-entry FIFO used as the output skid buffer of the read side.
// The head word stays put until it is popped, so the consumer sees stable data
// while it stalls.
// Ports:
//   clk_i    : clock
//   rst_i    : synchronous active-high reset (empties the buffer)
//   push_i   : write din_i this cycle
//   din_i    : word to store
//   pop_i    : remove the head word this cycle (ignored when empty)
//   count_o  : number of stored words, 0..2
//   head_o   : oldest stored word (meaningful only when count_o != 0)
// ----------------------------------------------------------------------------
module fwft_skid2 #(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] din_i,
    input  logic              pop_i,
    output logic [1:0]        count_o,
    output logic [DATA_W-1:0] head_o
);

    logic [DATA_W-1:0] slot_q [2];
    logic              wr_idx_q, wr_idx_d;
    logic              rd_idx_q, rd_idx_d;
    logic [1:0]        count_q, count_d;
    logic              do_push, do_pop;

    assign do_pop  = pop_i & (count_q != 2'd0);
    // A push into a full buffer is only legal if the head leaves at the same time.
    assign do_push = push_i & ((count_q != 2'd2) | do_pop);

    always_comb begin
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        count_d  = count_q;
        if (do_push) begin
            wr_idx_d = ~wr_idx_q;
        end
        if (do_pop) begin
            rd_idx_d = ~rd_idx_q;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_idx_q <= 1'b0;
            rd_idx_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            slot_q[wr_idx_q] <= din_i;
        end
    end

    assign count_o = count_q;
    assign head_o  = slot_q[rd_idx_q];

endmodule

// File: rtl/readptr_empty_fwft.sv
// ----------------------------------------------------------------------------
// readptr_empty_fwft
// Read-domain control of the asynchronous FIFO. Keeps the read binary/Gray
// pointers, the registered empty flag and fill level, fetches words from the
// dual-port RAM (1-cycle synchronous read) into a 2-entry skid buffer, and
// presents them first-word-fall-through over valid/ready.
// Ports:
//   r_clk, r_rst    : read clock, synchronous active-high reset
//   rq2_wptr        : write Gray pointer already synchronised into r_clk
//   raddr, r_fetch  : RAM read address / read enable
//   mem_rdata       : RAM data, valid the cycle after r_fetch
//   r_ptr           : registered read Gray pointer, sent to the write domain
//   r_empty         : no unfetched words in the RAM
//   r_level         : count of unfetched RAM words
//   r_almost_empty  : r_level <= Ae_thresh
//   r_valid, r_data : head-of-FIFO word and its valid flag
//   r_ready         : consumer takes r_data when r_valid & r_ready
// Addr_size must not exceed GRAY_MAX_W-1.
// ----------------------------------------------------------------------------
module readptr_empty_fwft
    import fifo_pkg::*;
#(
    parameter int Addr_size  = FIFO_ADDR_SIZE,
    parameter int Data_width = FIFO_DATA_WIDTH,
    parameter int Ae_thresh  = 4
) (
    input  logic                  r_clk,
    input  logic                  r_rst,
    input  logic [Addr_size:0]    rq2_wptr,
    output logic [Addr_size-1:0]  raddr,
    output logic                  r_fetch,
    input  logic [Data_width-1:0] mem_rdata,
    output logic [Addr_size:0]    r_ptr,
    output logic                  r_empty,
    output logic [Addr_size:0]    r_level,
    output logic                  r_almost_empty,
    output logic                  r_valid,
    output logic [Data_width-1:0] r_data,
    input  logic                  r_ready
);

    localparam int            PW     = Addr_size + 1;
    localparam logic [PW-1:0] AE_LIM = PW'(Ae_thresh);

    logic [PW-1:0]         rbin_q, rbin_d;
    logic [PW-1:0]         rptr_q, rptr_d;
    logic [PW-1:0]         level_q, level_d;
    logic [PW-1:0]         wbin_s;
    logic                  empty_q, empty_d;
    logic                  ae_q, ae_d;
    logic                  inflight_q;
    logic                  pop;
    logic [1:0]            skid_count;
    logic [2:0]            occupancy;
    logic [Data_width-1:0] skid_head;

    assign pop = r_valid & r_ready;

    // Words that will sit in the skid next cycle if nothing new is fetched.
    // Fetching only while this is below 2 guarantees the skid never overflows.
    assign occupancy = {1'b0, skid_count} + {2'b00, inflight_q} - {2'b00, pop};
    assign r_fetch   = ~empty_q & (occupancy < 3'd2);

    assign rbin_d  = rbin_q + {{Addr_size{1'b0}}, r_fetch};
    assign rptr_d  = PW'(bin2gray(32'(rbin_d)));
    assign wbin_s  = PW'(gray2bin(32'(rq2_wptr)));
    // Modulo-2**PW difference; the extra pointer bit keeps "full" (= depth)
    // distinct from "empty" (= 0).
    assign level_d = wbin_s - rbin_d;
    assign empty_d = (rptr_d == rq2_wptr);
    assign ae_d    = (level_d <= AE_LIM);

    always_ff @(posedge r_clk) begin
        if (r_rst) begin
            rbin_q     <= '0;
            rptr_q     <= '0;
            empty_q    <= 1'b1;
            level_q    <= '0;
            ae_q       <= 1'b1;
            inflight_q <= 1'b0;
        end else begin
            rbin_q     <= rbin_d;
            rptr_q     <= rptr_d;
            empty_q    <= empty_d;
            level_q    <= level_d;
            ae_q       <= ae_d;
            inflight_q <= r_fetch;
        end
    end

    // RAM data returning for a fetch issued before reset is dropped because
    // inflight_q is cleared by reset.
    fwft_skid2 #(
        .DATA_W (Data_width)
    ) u_skid (
        .clk_i   (r_clk),
        .rst_i   (r_rst),
        .push_i  (inflight_q),
        .din_i   (mem_rdata),
        .pop_i   (pop),
        .count_o (skid_count),
        .head_o  (skid_head)
    );

    assign raddr          = rbin_q[Addr_size-1:0];
    assign r_ptr          = rptr_q;
    assign r_empty        = empty_q;
    assign r_level        = level_q;
    assign r_almost_empty = ae_q;
    assign r_valid        = (skid_count != 2'd0);
    assign r_data         = skid_head;

endmodule

// File: tb/tb_readptr_empty_fwft.sv
module tb_readptr_empty_fwft;

    localparam int AW    = 9;
    localparam int DW    = 32;
    localparam int AE    = 4;
    localparam int PW    = AW + 1;
    localparam int DEPTH = 1 << AW;
    localparam int PMOD  = 1 << PW;

    logic          r_clk = 1'b0;
    logic          r_rst;
    logic [AW:0]   rq2_wptr;
    logic [AW-1:0] raddr;
    logic          r_fetch;
    logic [DW-1:0] mem_rdata;
    logic [AW:0]   r_ptr;
    logic          r_empty;
    logic [AW:0]   r_level;
    logic          r_almost_empty;
    logic          r_valid;
    logic [DW-1:0] r_data;
    logic          r_ready;

    always #5 r_clk = ~r_clk;

    readptr_empty_fwft #(
        .Addr_size  (AW),
        .Data_width (DW),
        .Ae_thresh  (AE)
    ) dut (
        .r_clk          (r_clk),
        .r_rst          (r_rst),
        .rq2_wptr       (rq2_wptr),
        .raddr          (raddr),
        .r_fetch        (r_fetch),
        .mem_rdata      (mem_rdata),
        .r_ptr          (r_ptr),
        .r_empty        (r_empty),
        .r_level        (r_level),
        .r_almost_empty (r_almost_empty),
        .r_valid        (r_valid),
        .r_data         (r_data),
        .r_ready        (r_ready)
    );

    // Synchronous-read RAM written directly by the bench.
    logic [DW-1:0] ram [DEPTH];
    always_ff @(posedge r_clk) begin
        if (r_fetch) mem_rdata <= ram[raddr];
    end

    int errors = 0;
    int checks = 0;

    // Reference model: FIFO described as counts of written / fetched words and
    // a queue of log indices waiting in the output buffer.
    logic [DW-1:0] log_q [$];
    int            skid_m [$];
    int            wr_cnt, rd_cnt, ptr_base;
    bit            inflight_m;
    int            inflight_idx;
    bit            empty_m, ae_m;
    int            level_m;
    bit            pop_m, fetch_m;
    int            fetch_log [$];
    int            pop_count;

    function automatic logic [AW:0] gray_of(input int b);
        logic [AW:0] v;
        v = PW'(b);
        return v ^ (v >> 1);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        wr_cnt       = 0;
        rd_cnt       = 0;
        ptr_base     = log_q.size();
        skid_m.delete();
        inflight_m   = 1'b0;
        inflight_idx = 0;
        empty_m      = 1'b1;
        level_m      = 0;
        ae_m         = 1'b1;
    endtask

    task automatic write_words(input int n);
        logic [DW-1:0] w;
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            ram[AW'(wr_cnt)] = w;
            log_q.push_back(w);
            wr_cnt++;
        end
        rq2_wptr = gray_of(wr_cnt);
    endtask

    task automatic sample();
        @(negedge r_clk);
        pop_m   = (skid_m.size() != 0) && r_ready;
        fetch_m = !empty_m && ((skid_m.size() + int'(inflight_m) - int'(pop_m)) < 2);
        chk("r_fetch", 64'(r_fetch), 64'(fetch_m));
        if (fetch_m) chk("raddr", 64'(raddr), 64'(rd_cnt % DEPTH));
        chk("r_valid", 64'(r_valid), 64'(skid_m.size() != 0));
        if (skid_m.size() != 0) chk("r_data", 64'(r_data), 64'(log_q[skid_m[0]]));
        chk("r_empty", 64'(r_empty), 64'(empty_m));
        chk("r_level", 64'(r_level), 64'(level_m));
        chk("r_almost_empty", 64'(r_almost_empty), 64'(ae_m));
        chk("r_ptr", 64'(r_ptr), 64'(gray_of(rd_cnt)));
        if (r_fetch) fetch_log.push_back(int'(raddr));
        if (r_valid && r_ready) pop_count++;
    endtask

    task automatic advance();
        @(posedge r_clk);
        if (r_rst) begin
            model_reset();
        end else begin
            if (pop_m) void'(skid_m.pop_front());
            if (inflight_m) skid_m.push_back(inflight_idx);
            inflight_m   = fetch_m;
            inflight_idx = ptr_base + rd_cnt;
            if (fetch_m) rd_cnt++;
            level_m = (wr_cnt - rd_cnt) % PMOD;
            empty_m = (level_m == 0);
            ae_m    = (level_m <= AE);
        end
        #1;
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    typedef struct {
        int add;
        bit rdy;
        int ncyc;
        int lvl;
        bit emp;
        bit ae;
        bit vld;
    } vec_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [8];
        int   first, last, k, n, zero_seen;

        tbl[0] = '{add: 0,   rdy: 0, ncyc: 2,   lvl: 0,   emp: 1, ae: 1, vld: 0};
        tbl[1] = '{add: 10,  rdy: 0, ncyc: 6,   lvl: 8,   emp: 0, ae: 0, vld: 1};
        tbl[2] = '{add: 0,   rdy: 1, ncyc: 20,  lvl: 0,   emp: 1, ae: 1, vld: 0};
        tbl[3] = '{add: 3,   rdy: 0, ncyc: 6,   lvl: 1,   emp: 0, ae: 1, vld: 1};
        tbl[4] = '{add: 0,   rdy: 1, ncyc: 10,  lvl: 0,   emp: 1, ae: 1, vld: 0};
        tbl[5] = '{add: 4,   rdy: 0, ncyc: 6,   lvl: 2,   emp: 0, ae: 1, vld: 1};
        tbl[6] = '{add: 510, rdy: 0, ncyc: 4,   lvl: 512, emp: 0, ae: 0, vld: 1};
        tbl[7] = '{add: 0,   rdy: 1, ncyc: 530, lvl: 0,   emp: 1, ae: 1, vld: 0};

        // Reset with an idle write pointer.
        r_rst    = 1'b1;
        rq2_wptr = '0;
        r_ready  = 1'b0;
        wr_cnt   = 0;
        repeat (3) @(posedge r_clk);
        model_reset();
        #1;
        sample();
        chk("rst_empty", 64'(r_empty), 64'd1);
        chk("rst_valid", 64'(r_valid), 64'd0);
        chk("rst_ptr", 64'(r_ptr), 64'd0);
        chk("rst_level", 64'(r_level), 64'd0);
        chk("rst_ae", 64'(r_almost_empty), 64'd1);
        chk("rst_fetch", 64'(r_fetch), 64'd0);
        advance();
        r_rst = 1'b0;
        step();

        // Single word: one fetch pulse, data two cycles after the fetch.
        r_ready = 1'b1;
        write_words(1);
        sample(); chk("t2_no_fetch_yet", 64'(r_fetch), 64'd0); advance();
        sample(); chk("t2_fetch", 64'(r_fetch), 64'd1); chk("t2_raddr", 64'(raddr), 64'd0); advance();
        sample();
        chk("t2_single_pulse", 64'(r_fetch), 64'd0);
        chk("t2_ptr", 64'(r_ptr), 64'd1);
        chk("t2_empty_again", 64'(r_empty), 64'd1);
        chk("t2_not_yet_valid", 64'(r_valid), 64'd0);
        advance();
        sample();
        chk("t2_valid", 64'(r_valid), 64'd1);
        chk("t2_data", 64'(r_data), 64'(log_q[ptr_base]));
        advance();
        sample(); chk("t2_consumed", 64'(r_valid), 64'd0); advance();

        // Burst of 20 with r_ready high: one word per cycle, back to back.
        write_words(20);
        pop_count = 0;
        first = -1;
        last  = -1;
        for (int c = 0; c < 30; c++) begin
            sample();
            if (r_valid && r_ready) begin
                if (first < 0) first = c;
                last = c;
            end
            advance();
        end
        chk("t3_pops", 64'(pop_count), 64'd20);
        chk("t3_back_to_back", 64'(last - first + 1), 64'd20);

        // Table: stall / drain / full-RAM vectors.
        for (int i = 0; i < 8; i++) begin
            r_ready = tbl[i].rdy;
            write_words(tbl[i].add);
            repeat (tbl[i].ncyc) step();
            sample();
            chk($sformatf("tbl%0d_level", i), 64'(r_level), 64'(tbl[i].lvl));
            chk($sformatf("tbl%0d_empty", i), 64'(r_empty), 64'(tbl[i].emp));
            chk($sformatf("tbl%0d_ae", i), 64'(r_almost_empty), 64'(tbl[i].ae));
            chk($sformatf("tbl%0d_valid", i), 64'(r_valid), 64'(tbl[i].vld));
            if (tbl[i].lvl == DEPTH)
                chk("full_gray_top_bits", 64'(r_ptr ^ rq2_wptr), 64'(10'b11_0000_0000));
            advance();
        end

        // Move the read pointer to 1020, then read 8 words across the wrap.
        r_ready = 1'b1;
        k = (1020 - (rd_cnt % PMOD) + PMOD) % PMOD;
        while (k > 0) begin
            n = (k > 400) ? 400 : k;
            write_words(n);
            repeat (n + 8) step();
            k -= n;
        end
        fetch_log.delete();
        zero_seen = 0;
        write_words(8);
        for (int c = 0; c < 16; c++) begin
            sample();
            if (r_ptr == '0) zero_seen = 1;
            advance();
        end
        chk("wrap_fetches", 64'(fetch_log.size()), 64'd8);
        for (int i = 0; i < 8 && i < fetch_log.size(); i++)
            chk($sformatf("wrap_raddr%0d", i), 64'(fetch_log[i]), 64'((508 + i) % DEPTH));
        chk("wrap_ptr_zero", 64'(zero_seen), 64'd1);

        // Randomised traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            r_ready = ($urandom_range(0, 99) < ((c < 1500) ? 30 : 85));
            if ($urandom_range(0, 2) == 0) begin
                n = $urandom_range(0, 4);
                if (wr_cnt - rd_cnt + n <= DEPTH) write_words(n);
            end
            step();
        end
        r_ready = 1'b1;
        repeat (530) step();
        sample();
        chk("rand_drained", 64'(r_valid), 64'd0);
        advance();

        // Reset while a fetch is in flight and the skid holds a word.
        r_ready = 1'b0;
        write_words(10);
        repeat (3) step();
        r_rst    = 1'b1;
        rq2_wptr = '0;
        step();
        sample();
        chk("mid_rst_valid", 64'(r_valid), 64'd0);
        chk("mid_rst_empty", 64'(r_empty), 64'd1);
        chk("mid_rst_level", 64'(r_level), 64'd0);
        chk("mid_rst_ae", 64'(r_almost_empty), 64'd1);
        chk("mid_rst_ptr", 64'(r_ptr), 64'd0);
        chk("mid_rst_fetch", 64'(r_fetch), 64'd0);
        advance();
        r_rst   = 1'b0;
        r_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            sample();
            chk("post_rst_no_stale", 64'(r_valid), 64'd0);
            advance();
        end
        write_words(2);
        repeat (8) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
